// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master, one-slave arbiter for the machine memory bus (bram / spram /
// led / uart decode sits behind the slave port). Master 0 is the cpu, master 1
// a secondary requester (DMA or debug loader). One transaction is in flight at
// a time. Arbitration is round-robin (PRIO = 0) or fixed with master 0 always
// winning (PRIO = 1). Reads are guarded by a timeout so an unmapped address
// cannot hang the requesting master.
//
// Parameters
//   W        data width
//   AW       address width
//   TIMEOUT  cycles s_rd_en may stay high without s_rd_valid (1..65535)
//   PRIO     0 = round-robin, 1 = fixed priority to master 0
//
// Ports
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   mN_addr                    master N address, held while the request is pending
//   mN_rd_en / mN_wr_en        master N request levels (both set = write)
//   mN_wr_data / mN_wr_mask    master N write data and byte-lane mask
//   mN_rd_data                 read data returned to master N (held between reads)
//   mN_rd_valid / mN_wr_done   one-cycle completion pulses to master N
//   s_addr, s_wr_data, s_wr_mask  latched slave-side address / write payload
//   s_rd_en                    slave read enable, level until data or timeout
//   s_rd_data / s_rd_valid     slave read return
//   s_wr_en                    slave write enable, one cycle per write
//   grant                      index of master owning current/last transaction
//   busy                       high whenever the arbiter is not idle
//   err_timeout                one-cycle pulse when a read times out
//
// All outputs are registered.
//
// State table
//   state    | meaning
//   ---------+----------------------------------------------------------------
//   ST_IDLE  | waiting for a request; picks the winner and latches its command
//   ST_READ  | s_rd_en held high; waiting for s_rd_valid or timer expiry
//   ST_WRITE | s_wr_en high for this single cycle
//   ST_DONE  | completion pulse to the granted master; back to idle next cycle
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int W       = 32,
    parameter int AW      = 16,
    parameter int TIMEOUT = 255,
    parameter int PRIO    = 0
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] m0_addr,
    input  logic          m0_rd_en,
    input  logic          m0_wr_en,
    input  logic [W-1:0]  m0_wr_data,
    input  logic [3:0]    m0_wr_mask,
    output logic [W-1:0]  m0_rd_data,
    output logic          m0_rd_valid,
    output logic          m0_wr_done,

    input  logic [AW-1:0] m1_addr,
    input  logic          m1_rd_en,
    input  logic          m1_wr_en,
    input  logic [W-1:0]  m1_wr_data,
    input  logic [3:0]    m1_wr_mask,
    output logic [W-1:0]  m1_rd_data,
    output logic          m1_rd_valid,
    output logic          m1_wr_done,

    output logic [AW-1:0] s_addr,
    output logic          s_rd_en,
    input  logic [W-1:0]  s_rd_data,
    input  logic          s_rd_valid,
    output logic          s_wr_en,
    output logic [W-1:0]  s_wr_data,
    output logic [3:0]    s_wr_mask,

    output logic          grant,
    output logic          busy,
    output logic          err_timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // The read timer is a down-counter: loaded with TIMEOUT-1 on entry to
    // ST_READ and expiring when it reaches zero, which leaves s_rd_en high for
    // exactly TIMEOUT cycles when the slave never answers.
    localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT - 1);

    logic [1:0]    state;
    logic          last_grant;
    logic [15:0]   timer;

    logic          req0;
    logic          req1;
    logic          win;
    logic          win_wr;
    logic [AW-1:0] win_addr;
    logic [W-1:0]  win_wr_data;
    logic [3:0]    win_wr_mask;
    logic          timer_tc;

    assign req0     = m0_rd_en | m0_wr_en;
    assign req1     = m1_rd_en | m1_wr_en;
    assign timer_tc = (timer == 16'd0);

    // Winner selection. A lone requester always wins; on a tie fixed priority
    // hands it to master 0, round-robin to whichever master did not go last.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            if (PRIO != 0) begin
                win = 1'b0;
            end else begin
                win = ~last_grant;
            end
        end else begin
            win = req1;
        end
    end

    // Command of the winning master. Write enable dominates, so a master with
    // both enables set is served as a write.
    always_comb begin
        win_wr      = m0_wr_en;
        win_addr    = m0_addr;
        win_wr_data = m0_wr_data;
        win_wr_mask = m0_wr_mask;
        if (win) begin
            win_wr      = m1_wr_en;
            win_addr    = m1_addr;
            win_wr_data = m1_wr_data;
            win_wr_mask = m1_wr_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            timer       <= 16'd0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            s_addr      <= '0;
            s_rd_en     <= 1'b0;
            s_wr_en     <= 1'b0;
            s_wr_data   <= '0;
            s_wr_mask   <= 4'd0;
            m0_rd_data  <= '0;
            m0_rd_valid <= 1'b0;
            m0_wr_done  <= 1'b0;
            m1_rd_data  <= '0;
            m1_rd_valid <= 1'b0;
            m1_wr_done  <= 1'b0;
        end else begin
            // Completion pulses and the error flag last a single cycle.
            m0_rd_valid <= 1'b0;
            m0_wr_done  <= 1'b0;
            m1_rd_valid <= 1'b0;
            m1_wr_done  <= 1'b0;
            err_timeout <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        grant      <= win;
                        last_grant <= win;
                        s_addr     <= win_addr;
                        s_wr_data  <= win_wr_data;
                        s_wr_mask  <= win_wr_mask;
                        busy       <= 1'b1;
                        if (win_wr) begin
                            s_wr_en <= 1'b1;
                            state   <= ST_WRITE;
                        end else begin
                            s_rd_en <= 1'b1;
                            timer   <= TIMER_LOAD;
                            state   <= ST_READ;
                        end
                    end
                end

                ST_READ: begin
                    // Real data wins over expiry when both land in the same cycle.
                    if (s_rd_valid) begin
                        if (grant) begin
                            m1_rd_data  <= s_rd_data;
                            m1_rd_valid <= 1'b1;
                        end else begin
                            m0_rd_data  <= s_rd_data;
                            m0_rd_valid <= 1'b1;
                        end
                        s_rd_en <= 1'b0;
                        state   <= ST_DONE;
                    end else if (timer_tc) begin
                        if (grant) begin
                            m1_rd_data  <= '0;
                            m1_rd_valid <= 1'b1;
                        end else begin
                            m0_rd_data  <= '0;
                            m0_rd_valid <= 1'b1;
                        end
                        err_timeout <= 1'b1;
                        s_rd_en     <= 1'b0;
                        state       <= ST_DONE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                ST_WRITE: begin
                    s_wr_en <= 1'b0;
                    if (grant) begin
                        m1_wr_done <= 1'b1;
                    end else begin
                        m0_wr_done <= 1'b1;
                    end
                    state <= ST_DONE;
                end

                ST_DONE: begin
                    // Requests are not sampled here: the master just saw its
                    // pulse and is dropping the request before the next edge.
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    s_rd_en <= 1'b0;
                    s_wr_en <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Two arbiter instances: index 0 is round-robin, index 1 fixed priority, both
// with an 8-cycle read timeout. Each instance has its own masters and slave.
// The reference model tracks one transaction as a start cycle and a computed
// completion cycle; every expected output for a cycle follows from where that
// cycle falls relative to those two numbers.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int W  = 32;
    localparam int AW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst         [2];
    logic [AW-1:0] m_addr      [2][2];
    logic          m_rd_en     [2][2];
    logic          m_wr_en     [2][2];
    logic [W-1:0]  m_wr_data   [2][2];
    logic [3:0]    m_wr_mask   [2][2];
    logic [W-1:0]  m_rd_data   [2][2];
    logic          m_rd_valid  [2][2];
    logic          m_wr_done   [2][2];
    logic [AW-1:0] s_addr      [2];
    logic          s_rd_en     [2];
    logic [W-1:0]  s_rd_data   [2];
    logic          s_rd_valid  [2];
    logic          s_wr_en     [2];
    logic [W-1:0]  s_wr_data   [2];
    logic [3:0]    s_wr_mask   [2];
    logic          grant       [2];
    logic          busy        [2];
    logic          err_timeout [2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        bus_arbiter #(.W(W), .AW(AW), .TIMEOUT(TO), .PRIO(d)) u_dut (
            .clk         (clk),
            .rst         (rst[d]),
            .m0_addr     (m_addr[d][0]),
            .m0_rd_en    (m_rd_en[d][0]),
            .m0_wr_en    (m_wr_en[d][0]),
            .m0_wr_data  (m_wr_data[d][0]),
            .m0_wr_mask  (m_wr_mask[d][0]),
            .m0_rd_data  (m_rd_data[d][0]),
            .m0_rd_valid (m_rd_valid[d][0]),
            .m0_wr_done  (m_wr_done[d][0]),
            .m1_addr     (m_addr[d][1]),
            .m1_rd_en    (m_rd_en[d][1]),
            .m1_wr_en    (m_wr_en[d][1]),
            .m1_wr_data  (m_wr_data[d][1]),
            .m1_wr_mask  (m_wr_mask[d][1]),
            .m1_rd_data  (m_rd_data[d][1]),
            .m1_rd_valid (m_rd_valid[d][1]),
            .m1_wr_done  (m_wr_done[d][1]),
            .s_addr      (s_addr[d]),
            .s_rd_en     (s_rd_en[d]),
            .s_rd_data   (s_rd_data[d]),
            .s_rd_valid  (s_rd_valid[d]),
            .s_wr_en     (s_wr_en[d]),
            .s_wr_data   (s_wr_data[d]),
            .s_wr_mask   (s_wr_mask[d]),
            .grant       (grant[d]),
            .busy        (busy[d]),
            .err_timeout (err_timeout[d])
        );
    end

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Bench masters: op 0 = read, 1 = write, 2 = both enables (served as write).
    bit            m_pend [2][2];
    int            m_op   [2][2];
    logic [AW-1:0] q_addr [2][2];
    logic [W-1:0]  q_data [2][2];
    logic [3:0]    q_mask [2][2];

    int            auto_pct  [2];
    bit            cont      [2];
    bit            rst_req   [2];
    int            force_k   [2];
    bit            use_fdata [2];
    logic [W-1:0]  fdata     [2];
    bit            spur      [2];

    // Reference model: one transaction described by start/done cycles.
    bit            mvalid    [2];
    bit            t_act     [2];
    int            t_start   [2];
    int            t_done    [2];
    int            t_k       [2];
    bit            t_wr      [2];
    bit            t_to      [2];
    bit            t_own     [2];
    bit            lastg     [2];
    bit            e_grant   [2];
    logic [AW-1:0] e_addr    [2];
    logic [W-1:0]  e_wdata   [2];
    logic [3:0]    e_wmask   [2];
    logic [W-1:0]  e_rdata   [2][2];
    logic [W-1:0]  cap       [2];
    int            next_free [2];

    int obs_rden [2];
    int obs_err  [2];
    int obs_rv   [2][2];
    int obs_wd   [2][2];
    bit wr_seq [$];
    int wd0_cyc [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset(input int d);
        mvalid[d]     = 1'b1;
        t_act[d]      = 1'b0;
        lastg[d]      = 1'b1;
        e_grant[d]    = 1'b0;
        e_addr[d]     = '0;
        e_wdata[d]    = '0;
        e_wmask[d]    = '0;
        e_rdata[d][0] = '0;
        e_rdata[d][1] = '0;
        next_free[d]  = cyc + 1;
    endtask

    task automatic arbitrate(input int d);
        bit r0;
        bit r1;
        bit w;
        int k;
        r0 = m_pend[d][0];
        r1 = m_pend[d][1];
        if (!r0 && !r1) return;
        if (r0 && r1) w = (d == 1) ? 1'b0 : !lastg[d];
        else          w = r1;
        t_act[d]   = 1'b1;
        t_start[d] = cyc;
        t_own[d]   = w;
        t_wr[d]    = (m_op[d][w] != 0);
        e_addr[d]  = q_addr[d][w];
        e_wdata[d] = q_data[d][w];
        e_wmask[d] = q_mask[d][w];
        lastg[d]   = w;
        e_grant[d] = w;
        if (t_wr[d]) begin
            t_done[d] = cyc + 2;
            t_to[d]   = 1'b0;
        end else begin
            k = (force_k[d] >= 0) ? force_k[d] : int'($urandom_range(TO + 1));
            t_k[d] = k;
            if (k <= TO - 1) begin
                t_done[d] = cyc + 2 + k;
                t_to[d]   = 1'b0;
            end else begin
                t_done[d] = cyc + 1 + TO;
                t_to[d]   = 1'b1;
            end
        end
        next_free[d] = t_done[d] + 1;
    endtask

    task automatic new_req(input int d, input int n, input int op,
                           input logic [AW-1:0] a, input logic [W-1:0] dt, input logic [3:0] mk);
        m_pend[d][n] = 1'b1;
        m_op[d][n]   = op;
        q_addr[d][n] = a;
        q_data[d][n] = dt;
        q_mask[d][n] = mk;
    endtask

    task automatic clr_obs();
        for (int d = 0; d < 2; d++) begin
            obs_rden[d] = 0;
            obs_err[d]  = 0;
            for (int n = 0; n < 2; n++) begin
                obs_rv[d][n] = 0;
                obs_wd[d][n] = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            bit win_rd;
            bit exp_wr_en;
            bit exp_busy;
            bit pulse;
            bit exp_rv [2];
            bit exp_wd [2];
            win_rd    = t_act[d] && !t_wr[d] && cyc >= t_start[d] + 1 && cyc <= t_done[d] - 1;
            exp_wr_en = t_act[d] && t_wr[d] && cyc == t_start[d] + 1;
            exp_busy  = t_act[d] && cyc >= t_start[d] + 1 && cyc <= t_done[d];
            pulse     = t_act[d] && cyc == t_done[d];
            for (int n = 0; n < 2; n++) begin
                exp_rv[n] = pulse && !t_wr[d] && (int'(t_own[d]) == n);
                exp_wd[n] = pulse && t_wr[d] && (int'(t_own[d]) == n);
            end
            if (pulse && !t_wr[d]) e_rdata[d][t_own[d]] = t_to[d] ? '0 : cap[d];

            if (mvalid[d]) begin
                check($sformatf("d%0d_ctl", d),
                      {s_rd_en[d], s_wr_en[d], busy[d], err_timeout[d],
                       m_rd_valid[d][0], m_rd_valid[d][1], m_wr_done[d][0], m_wr_done[d][1], grant[d]},
                      {win_rd, exp_wr_en, exp_busy, pulse && t_to[d],
                       exp_rv[0], exp_rv[1], exp_wd[0], exp_wd[1], e_grant[d]});
                check($sformatf("d%0d_s_addr", d), s_addr[d], e_addr[d]);
                check($sformatf("d%0d_s_wr_data", d), s_wr_data[d], e_wdata[d]);
                check($sformatf("d%0d_s_wr_mask", d), s_wr_mask[d], e_wmask[d]);
                check($sformatf("d%0d_m0_rd_data", d), m_rd_data[d][0], e_rdata[d][0]);
                check($sformatf("d%0d_m1_rd_data", d), m_rd_data[d][1], e_rdata[d][1]);
            end

            obs_rden[d] += int'(s_rd_en[d] === 1'b1);
            obs_err[d]  += int'(err_timeout[d] === 1'b1);
            for (int n = 0; n < 2; n++) begin
                obs_rv[d][n] += int'(m_rd_valid[d][n] === 1'b1);
                obs_wd[d][n] += int'(m_wr_done[d][n] === 1'b1);
            end
            if (d == 0 && s_wr_en[0] === 1'b1) wr_seq.push_back(grant[0]);
            if (d == 1 && m_wr_done[1][0] === 1'b1) wd0_cyc.push_back(cyc);

            // Masters drop their request in the cycle they see completion.
            for (int n = 0; n < 2; n++)
                if (m_pend[d][n] && (exp_rv[n] || exp_wd[n]) && !cont[d]) m_pend[d][n] = 1'b0;
            if (rst_req[d]) begin
                m_pend[d][0] = 1'b0;
                m_pend[d][1] = 1'b0;
            end else begin
                for (int n = 0; n < 2; n++)
                    if (!m_pend[d][n] && auto_pct[d] > 0 && int'($urandom_range(99)) < auto_pct[d])
                        new_req(d, n, int'($urandom_range(2)), AW'($urandom), $urandom, 4'($urandom));
            end
            for (int n = 0; n < 2; n++) begin
                m_rd_en[d][n]   = m_pend[d][n] && (m_op[d][n] != 1);
                m_wr_en[d][n]   = m_pend[d][n] && (m_op[d][n] != 0);
                m_addr[d][n]    = m_pend[d][n] ? q_addr[d][n] : AW'($urandom);
                m_wr_data[d][n] = m_pend[d][n] ? q_data[d][n] : $urandom;
                m_wr_mask[d][n] = m_pend[d][n] ? q_mask[d][n] : 4'($urandom);
            end
            rst[d] = rst_req[d];

            if (rst_req[d]) model_reset(d);
            else if (mvalid[d] && cyc >= next_free[d]) arbitrate(d);

            s_rd_data[d] = use_fdata[d] ? fdata[d] : $urandom;
            if (win_rd) begin
                s_rd_valid[d] = (cyc == t_start[d] + 1 + t_k[d]);
                if (s_rd_valid[d]) cap[d] = s_rd_data[d];
            end else begin
                s_rd_valid[d] = spur[d] && ($urandom_range(3) == 0);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit [7:0] ov;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;       rst_req[d] = 1'b1;
            auto_pct[d] = 0;     cont[d] = 1'b0;
            force_k[d] = -1;     use_fdata[d] = 1'b0;
            fdata[d] = '0;       spur[d] = 1'b0;
            mvalid[d] = 1'b0;    t_act[d] = 1'b0;
            s_rd_valid[d] = 1'b0; s_rd_data[d] = '0;
            for (int n = 0; n < 2; n++) begin
                m_pend[d][n] = 1'b0; m_op[d][n] = 0;
                q_addr[d][n] = '0;   q_data[d][n] = '0; q_mask[d][n] = '0;
                m_rd_en[d][n] = 1'b0; m_wr_en[d][n] = 1'b0;
                m_addr[d][n] = '0;   m_wr_data[d][n] = '0; m_wr_mask[d][n] = '0;
            end
        end
        run(2);
        rst_req[0] = 1'b0;
        rst_req[1] = 1'b0;
        run(2);

        // m0 read, slave answers one cycle after s_rd_en rises.
        clr_obs();
        force_k[0] = 1; use_fdata[0] = 1'b1; fdata[0] = 32'hCAFEBABE;
        new_req(0, 0, 0, 16'h0010, 32'h0, 4'h0);
        run(6);
        check("t1_m0_rv_cnt", obs_rv[0][0], 1);
        check("t1_m1_silent", obs_rv[0][1] + obs_wd[0][1], 0);
        check("t1_m0_data", m_rd_data[0][0], 32'hCAFEBABE);

        // Dual writes right after reset, round-robin: order 0,1,0,1,...
        rst_req[0] = 1'b1; step(); rst_req[0] = 1'b0;
        wr_seq.delete();
        for (int b = 0; b < 4; b++) begin
            new_req(0, 0, 1, AW'($urandom), $urandom, 4'($urandom));
            new_req(0, 1, 1, AW'($urandom), $urandom, 4'($urandom));
            run(7);
        end
        ov = '0;
        for (int i = 0; i < 8 && i < wr_seq.size(); i++) ov[i] = wr_seq[i];
        check("t2_wr_count", wr_seq.size(), 8);
        check("t2_order", ov, 8'b1010_1010);

        // Fixed priority with both masters requesting continuously.
        clr_obs();
        wd0_cyc.delete();
        cont[1] = 1'b1;
        new_req(1, 0, 1, 16'h0100, 32'h1111_0000, 4'hF);
        new_req(1, 1, 1, 16'h0200, 32'h2222_0000, 4'h3);
        run(30);
        check("t3_m1_never", obs_wd[1][1], 0);
        check("t3_m0_count", wd0_cyc.size(), 10);
        for (int i = 1; i < wd0_cyc.size(); i++) check("t3_gap", wd0_cyc[i] - wd0_cyc[i-1], 3);
        cont[1] = 1'b0;
        run(12);

        // m1 read that never gets an answer, after a normal m1 read.
        force_k[0] = 2; fdata[0] = 32'h1234_5678;
        new_req(0, 1, 0, 16'h7000, 32'h0, 4'h0);
        run(6);
        check("t4_pre_data", m_rd_data[0][1], 32'h1234_5678);
        clr_obs();
        force_k[0] = TO + 1;
        new_req(0, 1, 0, 16'h7000, 32'h0, 4'h0);
        run(13);
        check("t4_rd_en_cycles", obs_rden[0], TO);
        check("t4_err_cnt", obs_err[0], 1);
        check("t4_m1_rv_cnt", obs_rv[0][1], 1);
        check("t4_m1_data", m_rd_data[0][1], 32'h0);

        // Answer on the last cycle before expiry wins.
        clr_obs();
        force_k[0] = TO - 1; fdata[0] = 32'h5A5A_A5A5;
        new_req(0, 0, 0, 16'h0100, 32'h0, 4'h0);
        run(13);
        check("t5_rd_en_cycles", obs_rden[0], TO);
        check("t5_err_cnt", obs_err[0], 0);
        check("t5_m0_rv_cnt", obs_rv[0][0], 1);
        check("t5_m0_data", m_rd_data[0][0], 32'h5A5A_A5A5);

        // Reset in the middle of a read aborts it silently.
        force_k[0] = TO + 1;
        new_req(0, 0, 0, 16'h0200, 32'h0, 4'h0);
        run(3);
        rst_req[0] = 1'b1; step(); rst_req[0] = 1'b0;
        step();
        check("t6_rd_en", s_rd_en[0], 1'b0);
        check("t6_busy", busy[0], 1'b0);
        clr_obs();
        run(12);
        check("t6_no_pulse", obs_rv[0][0] + obs_rv[0][1] + obs_err[0], 0);
        force_k[0] = 0; fdata[0] = 32'h0BAD_F00D;
        new_req(0, 0, 0, 16'h0300, 32'h0, 4'h0);
        run(5);
        check("t6_fresh_rv", obs_rv[0][0], 1);
        check("t6_fresh_data", m_rd_data[0][0], 32'h0BAD_F00D);

        // Random traffic on both instances, spurious slave valids, rare resets.
        for (int d = 0; d < 2; d++) begin
            force_k[d] = -1; use_fdata[d] = 1'b0; spur[d] = 1'b1; auto_pct[d] = 35;
        end
        for (int i = 0; i < 3000; i++) begin
            rst_req[0] = ($urandom_range(599) == 0);
            rst_req[1] = ($urandom_range(599) == 0);
            step();
        end
        rst_req[0] = 1'b0;
        rst_req[1] = 1'b0;
        auto_pct[0] = 0;
        auto_pct[1] = 0;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
